// File: rtl/mc_shared_mem_port.sv
// Shared data memory for the multicycle RISC-V core with a handshaked
// user/debug port. A single-port synchronous RAM is arbitrated every cycle:
// the core normally wins, and a starvation counter forces a user slot by
// stalling the core for one cycle.
module mc_shared_mem_port #(
    parameter int    XLEN       = 16,
    parameter int    AW         = 6,
    parameter int    STARVE_MAX = 4,
    parameter string INIT_FILE  = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_stall,
    input  logic            user_req,
    input  logic            user_we,
    input  logic [AW-1:0]   user_addr,
    input  logic [XLEN-1:0] user_wdata,
    output logic            user_busy,
    output logic            user_ack,
    output logic [XLEN-1:0] user_rdata
);

    localparam int DEPTH = 2 ** AW;
    localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW-1:0]   starve_cnt;
    logic [SW-1:0]   starve_cnt_nxt;

    logic            pend_we;
    logic [AW-1:0]   pend_addr;
    logic [XLEN-1:0] pend_wdata;

    logic            grant_user;
    logic            core_grant;

    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;

    logic [XLEN-1:0] mem [DEPTH];

    // User-side FSM state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Next state, user grant and starvation counting; the counter is zero
    // everywhere except while a pending request keeps losing to the core.
    always_comb begin
        state_nxt      = state;
        starve_cnt_nxt = '0;
        grant_user     = 1'b0;
        case (state)
            IDLE: begin
                if (user_req) state_nxt = PEND;
            end
            PEND: begin
                grant_user = !core_req || (starve_cnt >= STARVE_LIM);
                if (grant_user) begin
                    state_nxt = ACK;
                end else begin
                    starve_cnt_nxt = (starve_cnt >= STARVE_LIM) ? starve_cnt
                                                                : starve_cnt + 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration: exactly one RAM access per cycle, user slot first when granted.
    always_comb begin
        core_stall = core_req && grant_user;
        core_grant = core_req && !grant_user;
        if (grant_user) begin
            mem_we    = pend_we;
            mem_addr  = pend_addr;
            mem_wdata = pend_wdata;
        end else begin
            mem_we    = core_grant && core_we;
            mem_addr  = core_addr[AW-1:0];
            mem_wdata = core_wdata;
        end
    end

    // Capture the user request when it is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && user_req) begin
            pend_we    <= user_we;
            pend_addr  <= user_addr;
            pend_wdata <= user_wdata;
        end
    end

    // RAM write port; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Core read data register; holds unless a granted core read occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_rdata <= '0;
        end else if (core_grant && !core_we) begin
            core_rdata <= mem[mem_addr];
        end
    end

    // User read data register; loaded in the grant cycle so it is valid with the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            user_rdata <= '0;
        end else if (grant_user && !pend_we) begin
            user_rdata <= mem[mem_addr];
        end
    end

    assign user_busy = (state != IDLE);
    assign user_ack  = (state == ACK);

endmodule

// File: tb/tb_mc_shared_mem_port.sv
// Directed self-checking bench for mc_shared_mem_port.
module tb_mc_shared_mem_port;

    localparam int XLEN = 16;
    localparam int AW   = 6;

    logic            clk;
    logic            rst;
    logic            core_req;
    logic            core_we;
    logic [XLEN-1:0] core_addr;
    logic [XLEN-1:0] core_wdata;
    logic [XLEN-1:0] core_rdata;
    logic            core_stall;
    logic            user_req;
    logic            user_we;
    logic [AW-1:0]   user_addr;
    logic [XLEN-1:0] user_wdata;
    logic            user_busy;
    logic            user_ack;
    logic [XLEN-1:0] user_rdata;

    int errors = 0;
    int checks = 0;

    mc_shared_mem_port #(
        .XLEN      (16),
        .AW        (6),
        .STARVE_MAX(4),
        .INIT_FILE ("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .user_req  (user_req),
        .user_we   (user_we),
        .user_addr (user_addr),
        .user_wdata(user_wdata),
        .user_busy (user_busy),
        .user_ack  (user_ack),
        .user_rdata(user_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        user_req = 1'b0; user_we = 1'b0; user_addr = '0; user_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (core_rdata !== 16'h0000) begin errors++; $display("FAIL reset_core_rdata got=%h exp=0000", core_rdata); end
        checks++; if (user_rdata !== 16'h0000) begin errors++; $display("FAIL reset_user_rdata got=%h exp=0000", user_rdata); end
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL reset_user_ack got=%b exp=0", user_ack); end
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL reset_user_busy got=%b exp=0", user_busy); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall got=%b exp=0", core_stall); end
        rst = 1'b0;
    endtask

    task automatic test_core_rw;
        tick; core_req = 1'b1; core_we = 1'b1; core_addr = 16'd5; core_wdata = 16'h1234;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL core_wr_stall got=%b exp=0", core_stall); end
        tick; core_we = 1'b0;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL core_rd_stall got=%b exp=0", core_stall); end
        tick; core_we = 1'b1; core_addr = 16'd9; core_wdata = 16'h0909;
        @(negedge clk);
        checks++; if (core_rdata !== 16'h1234) begin errors++; $display("FAIL core_raw_data got=%h exp=1234", core_rdata); end
        tick; core_addr = 16'd63; core_wdata = 16'h00FF;
        tick; core_we = 1'b0;
        tick; core_req = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 16'h00FF) begin errors++; $display("FAIL core_top_addr got=%h exp=00ff", core_rdata); end
        tick;
        @(negedge clk);
        checks++; if (core_rdata !== 16'h00FF) begin errors++; $display("FAIL core_rdata_hold got=%h exp=00ff", core_rdata); end
    endtask

    task automatic test_user_read;
        tick; user_req = 1'b1; user_we = 1'b0; user_addr = 6'd5;
        @(negedge clk);
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL ur_busy_n got=%b exp=0", user_busy); end
        tick; user_req = 1'b0;
        @(negedge clk);
        checks++; if (user_busy !== 1'b1) begin errors++; $display("FAIL ur_busy_n1 got=%b exp=1", user_busy); end
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL ur_ack_n1 got=%b exp=0", user_ack); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL ur_stall_n1 got=%b exp=0", core_stall); end
        tick;
        @(negedge clk);
        checks++; if (user_busy !== 1'b1) begin errors++; $display("FAIL ur_busy_n2 got=%b exp=1", user_busy); end
        checks++; if (user_ack !== 1'b1) begin errors++; $display("FAIL ur_ack_n2 got=%b exp=1", user_ack); end
        checks++; if (user_rdata !== 16'h1234) begin errors++; $display("FAIL ur_rdata got=%h exp=1234", user_rdata); end
        tick;
        @(negedge clk);
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL ur_busy_n3 got=%b exp=0", user_busy); end
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL ur_ack_n3 got=%b exp=0", user_ack); end
        checks++; if (user_rdata !== 16'h1234) begin errors++; $display("FAIL ur_rdata_hold got=%h exp=1234", user_rdata); end
    endtask

    task automatic test_starve;
        tick;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'd5;
        user_req = 1'b1; user_we = 1'b1; user_addr = 6'd7; user_wdata = 16'hBEEF;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL st_stall_cap got=%b exp=0", core_stall); end
        tick; user_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (user_busy !== 1'b1) begin errors++; $display("FAIL st_pend_busy[%0d] got=%b exp=1", i, user_busy); end
            checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL st_pend_stall[%0d] got=%b exp=0", i, core_stall); end
            checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL st_pend_ack[%0d] got=%b exp=0", i, user_ack); end
            tick;
        end
        @(negedge clk);
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL st_grant_stall got=%b exp=1", core_stall); end
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL st_grant_ack got=%b exp=0", user_ack); end
        tick;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL st_ack_stall got=%b exp=0", core_stall); end
        checks++; if (user_ack !== 1'b1) begin errors++; $display("FAIL st_ack got=%b exp=1", user_ack); end
        checks++; if (user_rdata !== 16'h1234) begin errors++; $display("FAIL st_wr_rdata_hold got=%h exp=1234", user_rdata); end
        tick; core_addr = 16'd7;
        @(negedge clk);
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL st_ack_pulse got=%b exp=0", user_ack); end
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL st_idle_busy got=%b exp=0", user_busy); end
        tick; core_req = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 16'hBEEF) begin errors++; $display("FAIL st_readback got=%h exp=beef", core_rdata); end
    endtask

    task automatic test_reset_mid;
        tick;
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'd5;
        user_req = 1'b1; user_we = 1'b1; user_addr = 6'd9; user_wdata = 16'hAAAA;
        tick; user_req = 1'b0;
        @(negedge clk);
        checks++; if (user_busy !== 1'b1) begin errors++; $display("FAIL rm_pend_busy got=%b exp=1", user_busy); end
        tick; rst = 1'b1; core_req = 1'b0;
        tick; rst = 1'b0;
        @(negedge clk);
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", user_busy); end
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL rm_ack0 got=%b exp=0", user_ack); end
        checks++; if (user_rdata !== 16'h0000) begin errors++; $display("FAIL rm_user_rdata got=%h exp=0000", user_rdata); end
        tick; core_req = 1'b1; core_we = 1'b0; core_addr = 16'd9;
        @(negedge clk);
        checks++; if (user_ack !== 1'b0) begin errors++; $display("FAIL rm_ack1 got=%b exp=0", user_ack); end
        tick; core_req = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 16'h0909) begin errors++; $display("FAIL rm_mem9 got=%h exp=0909", core_rdata); end
    endtask

    task automatic test_hold_alias;
        logic exp_ack;
        logic exp_busy;
        tick; user_req = 1'b1; user_we = 1'b0; user_addr = 6'd9;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) user_req = 1'b0;
            exp_ack  = ((i % 3) == 2);
            exp_busy = ((i % 3) != 0);
            @(negedge clk);
            checks++; if (user_ack !== exp_ack) begin errors++; $display("FAIL hold_ack[%0d] got=%b exp=%b", i, user_ack, exp_ack); end
            checks++; if (user_busy !== exp_busy) begin errors++; $display("FAIL hold_busy[%0d] got=%b exp=%b", i, user_busy, exp_busy); end
            tick;
        end
        @(negedge clk);
        checks++; if (user_busy !== 1'b0) begin errors++; $display("FAIL hold_release got=%b exp=0", user_busy); end
        checks++; if (user_rdata !== 16'h0909) begin errors++; $display("FAIL hold_rdata got=%h exp=0909", user_rdata); end
        tick; core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0045; core_wdata = 16'h4545;
        tick; core_we = 1'b0; core_addr = 16'hFFC5;
        tick; core_req = 1'b0;
        @(negedge clk);
        checks++; if (core_rdata !== 16'h4545) begin errors++; $display("FAIL alias_core got=%h exp=4545", core_rdata); end
        tick; user_req = 1'b1; user_we = 1'b0; user_addr = 6'd5;
        tick; user_req = 1'b0;
        tick;
        @(negedge clk);
        checks++; if (user_ack !== 1'b1) begin errors++; $display("FAIL alias_user_ack got=%b exp=1", user_ack); end
        checks++; if (user_rdata !== 16'h4545) begin errors++; $display("FAIL alias_user got=%h exp=4545", user_rdata); end
    endtask

    initial begin
        test_reset;
        test_core_rw;
        test_user_read;
        test_starve;
        test_reset_mid;
        test_hold_alias;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
